// File: rtl/pulse_gen_pkg.sv
// pulse_gen_pkg: shared types and constants for the pulse_gen pulse-train
// transmitter.
//   DEFAULT_WIDTH : default width of the count inputs and internal counters
//   state_t       : transmitter phase (IDLE, ACTIVE, INACTIVE)
package pulse_gen_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    INACTIVE = 2'd2
  } state_t;

endpackage

// File: rtl/pulse_gen_timer.sv
// pulse_gen_timer: loadable down-counter used to time one pulse phase.
// Ports:
//   i_clk, i_rst  clock and asynchronous active-high reset
//   i_load        load i_load_val (has priority over i_en)
//   i_en          decrement by one when the count is non-zero
//   i_load_val    value to load
//   o_last        high while the count is 1, i.e. the final cycle of a phase
module pulse_gen_timer
  import pulse_gen_pkg::*;
#(
  parameter int W = DEFAULT_WIDTH
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_load_val,
  output logic         o_last
);

  logic [W-1:0] r_cnt;

  // Phase counter: load, or count down and hold at zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= {W{1'b0}};
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != {W{1'b0}})) begin
      r_cnt <= r_cnt - {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_last = (r_cnt == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/pulse_gen.sv
// pulse_gen: pulse-train transmitter. A one-cycle io_start (with a non-zero
// io_highCnt) launches a train of pulses, each made of an active phase driving
// ~io_defaultLevel for io_highCnt cycles followed by an idle phase of
// io_lowCnt cycles (0 treated as 1). io_busy covers the whole train and
// io_done strobes for one cycle as it ends. Configuration is latched at start.
// Optional feature macro: PULSE_GEN_REPEAT_EN adds io_pulseNum (pulses per
// start, 0 treated as 1); without it every start emits a single pulse.
// Ports:
//   io_clk, io_rst     clock, asynchronous active-high reset
//   io_start           start request, ignored while busy
//   io_highCnt         active phase length (0 = start ignored)
//   io_lowCnt          idle phase length after each pulse
//   io_pulseNum        pulses per start (PULSE_GEN_REPEAT_EN only)
//   io_defaultLevel    idle level
//   io_pulse_out       registered pulse output
//   io_busy, io_done   handshake outputs
module pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int _RAM_WIDTH = DEFAULT_WIDTH
) (
  input  logic                  io_clk,
  input  logic                  io_rst,
  input  logic                  io_start,
  input  logic [_RAM_WIDTH-1:0] io_highCnt,
  input  logic [_RAM_WIDTH-1:0] io_lowCnt,
`ifdef PULSE_GEN_REPEAT_EN
  input  logic [_RAM_WIDTH-1:0] io_pulseNum,
`endif
  input  logic                  io_defaultLevel,
  output logic                  io_pulse_out,
  output logic                  io_busy,
  output logic                  io_done
);

  localparam logic [_RAM_WIDTH-1:0] ZERO = {_RAM_WIDTH{1'b0}};
  localparam logic [_RAM_WIDTH-1:0] ONE  = {{(_RAM_WIDTH-1){1'b0}}, 1'b1};

  state_t                r_state;
  logic                  r_pulse_out;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_level;
  logic [_RAM_WIDTH-1:0] r_high;
  logic [_RAM_WIDTH-1:0] r_low;
`ifdef PULSE_GEN_REPEAT_EN
  logic [_RAM_WIDTH-1:0] r_left;
`endif

  logic                  w_accept;
  logic                  w_more;
  logic                  w_last;
  logic                  w_load;
  logic                  w_en;
  logic [_RAM_WIDTH-1:0] w_load_val;

  assign w_accept = io_start && (io_highCnt != ZERO);

`ifdef PULSE_GEN_REPEAT_EN
  assign w_more = (r_left > ONE);
`else
  assign w_more = 1'b0;
`endif

  // Timer control: load the next phase length on every phase boundary.
  always_comb begin
    w_load     = 1'b0;
    w_en       = 1'b0;
    w_load_val = ZERO;
    case (r_state)
      IDLE: begin
        w_load     = w_accept;
        w_load_val = io_highCnt;
      end
      ACTIVE: begin
        if (w_last) begin
          w_load     = 1'b1;
          w_load_val = r_low;
        end else begin
          w_en = 1'b1;
        end
      end
      INACTIVE: begin
        if (w_last) begin
          // Final pulse clears the counter so it rests at zero in IDLE.
          w_load     = 1'b1;
          w_load_val = w_more ? r_high : ZERO;
        end else begin
          w_en = 1'b1;
        end
      end
      default: begin
        w_load     = 1'b0;
        w_en       = 1'b0;
        w_load_val = ZERO;
      end
    endcase
  end

  pulse_gen_timer #(
    .W (_RAM_WIDTH)
  ) u_timer (
    .i_clk      (io_clk),
    .i_rst      (io_rst),
    .i_load     (w_load),
    .i_en       (w_en),
    .i_load_val (w_load_val),
    .o_last     (w_last)
  );

  // Train FSM with registered output, busy and done.
  always_ff @(posedge io_clk or posedge io_rst) begin
    if (io_rst) begin
      r_state     <= IDLE;
      r_pulse_out <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_level     <= 1'b0;
      r_high      <= ZERO;
      r_low       <= ZERO;
`ifdef PULSE_GEN_REPEAT_EN
      r_left      <= ZERO;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_state     <= ACTIVE;
            r_busy      <= 1'b1;
            r_pulse_out <= ~io_defaultLevel;
            r_level     <= io_defaultLevel;
            r_high      <= io_highCnt;
            r_low       <= (io_lowCnt == ZERO) ? ONE : io_lowCnt;
`ifdef PULSE_GEN_REPEAT_EN
            r_left      <= (io_pulseNum == ZERO) ? ONE : io_pulseNum;
`endif
          end else begin
            r_busy      <= 1'b0;
            r_pulse_out <= io_defaultLevel;
          end
        end
        ACTIVE: begin
          r_done <= 1'b0;
          if (w_last) begin
            r_state     <= INACTIVE;
            r_pulse_out <= r_level;
          end else begin
            r_pulse_out <= ~r_level;
          end
        end
        INACTIVE: begin
          if (w_last && w_more) begin
            r_state     <= ACTIVE;
            r_pulse_out <= ~r_level;
            r_done      <= 1'b0;
`ifdef PULSE_GEN_REPEAT_EN
            r_left      <= r_left - ONE;
`endif
          end else if (w_last) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_done <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_pulse_out <= r_level;
        end
      endcase
    end
  end

  assign io_pulse_out = r_pulse_out;
  assign io_busy      = r_busy;
  assign io_done      = r_done;

endmodule

// File: tb/tb_pulse_gen.sv
module tb_pulse_gen;

  logic        io_clk = 1'b0;
  logic        io_rst;
  logic        io_start;
  logic [31:0] io_highCnt;
  logic [31:0] io_lowCnt;
`ifdef PULSE_GEN_REPEAT_EN
  logic [31:0] io_pulseNum;
`endif
  logic        io_defaultLevel;
  logic        io_pulse_out;
  logic        io_busy;
  logic        io_done;

  typedef struct {
    logic lvl;
    int   h;
    int   l;
    int   n;
  } vec_t;

  typedef struct {
    logic out;
    logic busy;
    logic done;
  } exp_t;

  exp_t q[$];
  vec_t vecs[6];
  int   n_checks = 0;
  int   n_pass   = 0;

  pulse_gen dut (
    .io_clk          (io_clk),
    .io_rst          (io_rst),
    .io_start        (io_start),
    .io_highCnt      (io_highCnt),
    .io_lowCnt       (io_lowCnt),
`ifdef PULSE_GEN_REPEAT_EN
    .io_pulseNum     (io_pulseNum),
`endif
    .io_defaultLevel (io_defaultLevel),
    .io_pulse_out    (io_pulse_out),
    .io_busy         (io_busy),
    .io_done         (io_done)
  );

  always #5 io_clk = ~io_clk;

  task automatic check(string name, logic o, logic b, logic d);
    n_checks++;
    if ({io_pulse_out, io_busy, io_done} !== {o, b, d}) begin
      $display("FAIL %s t=%0t: got out/busy/done=%b%b%b, want %b%b%b",
               name, $time, io_pulse_out, io_busy, io_done, o, b, d);
    end else begin
      n_pass++;
    end
  endtask

  task automatic set_cfg(logic lvl, int h, int l, int n);
    io_defaultLevel = lvl;
    io_highCnt      = h;
    io_lowCnt       = l;
`ifdef PULSE_GEN_REPEAT_EN
    io_pulseNum     = n;
`else
    if (n < 0) io_lowCnt = l;
`endif
  endtask

  // Expected per-cycle output after the start edge, up to and including done.
  function automatic void push_train(logic lvl, int h, int l, int n);
    int le;
    int ne;
    exp_t e;
    le = (l == 0) ? 1 : l;
`ifdef PULSE_GEN_REPEAT_EN
    ne = (n == 0) ? 1 : n;
`else
    ne = 1;
`endif
    for (int p = 0; p < ne; p++) begin
      for (int i = 0; i < h; i++) begin
        e = '{out: ~lvl, busy: 1'b1, done: 1'b0};
        q.push_back(e);
      end
      for (int i = 0; i < le; i++) begin
        e = '{out: lvl, busy: 1'b1, done: 1'b0};
        q.push_back(e);
      end
    end
    e = '{out: lvl, busy: 1'b0, done: 1'b1};
    q.push_back(e);
  endfunction

  function automatic void push_idle(logic lvl);
    exp_t e;
    e = '{out: lvl, busy: 1'b0, done: 1'b0};
    q.push_back(e);
  endfunction

  // Compare queued expectations cycle by cycle; optionally pulse io_start with
  // scrambled counts while busy (both must be ignored by the running train).
  task automatic drain(string name, bit noise);
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      check(name, e.out, e.busy, e.done);
      if (noise && e.busy) begin
        io_start   = 1'b1;
        io_highCnt = $urandom_range(1, 40);
        io_lowCnt  = $urandom_range(0, 40);
`ifdef PULSE_GEN_REPEAT_EN
        io_pulseNum = $urandom_range(0, 9);
`endif
      end else begin
        io_start = 1'b0;
      end
      @(negedge io_clk);
    end
    io_start = 1'b0;
  endtask

  initial begin
    vecs[0] = '{lvl: 1'b0, h: 10, l: 10, n: 1};
    vecs[1] = '{lvl: 1'b1, h: 5,  l: 0,  n: 1};
    vecs[2] = '{lvl: 1'b0, h: 3,  l: 2,  n: 4};
    vecs[3] = '{lvl: 1'b1, h: 1,  l: 1,  n: 3};
    vecs[4] = '{lvl: 1'b0, h: 1,  l: 0,  n: 0};
    vecs[5] = '{lvl: 1'b1, h: 7,  l: 3,  n: 2};

    io_rst   = 1'b1;
    io_start = 1'b0;
    set_cfg(1'b1, 0, 0, 0);
    #2;
    check("reset_state", 1'b0, 1'b0, 1'b0);
    @(negedge io_clk);
    io_rst = 1'b0;
    @(negedge io_clk);
    check("idle_follow", 1'b1, 1'b0, 1'b0);

    // Table-driven trains.
    foreach (vecs[k]) begin
      set_cfg(vecs[k].lvl, vecs[k].h, vecs[k].l, vecs[k].n);
      io_start = 1'b1;
      push_train(vecs[k].lvl, vecs[k].h, vecs[k].l, vecs[k].n);
      push_idle(vecs[k].lvl);
      @(negedge io_clk);
      io_start = 1'b0;
      set_cfg(vecs[k].lvl, 0, 0, 0);
      drain($sformatf("train%0d", k), 1'b1);
    end

    // highCnt == 0: start ignored, output just follows the idle level.
    set_cfg(1'b0, 0, 4, 2);
    io_start = 1'b1;
    @(negedge io_clk);
    io_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("zero_high", 1'b0, 1'b0, 1'b0);
      @(negedge io_clk);
    end

    // Restart in the done cycle: second train begins on the very next edge.
    begin
      exp_t e;
      bit   restarted;
      restarted = 1'b0;
      set_cfg(1'b0, 4, 2, 1);
      io_start = 1'b1;
      push_train(1'b0, 4, 2, 1);
      @(negedge io_clk);
      io_start = 1'b0;
      while (q.size() > 0) begin
        e = q.pop_front();
        check("restart", e.out, e.busy, e.done);
        if (e.done && !restarted) begin
          restarted = 1'b1;
          set_cfg(1'b1, 2, 3, 2);
          io_start = 1'b1;
          push_train(1'b1, 2, 3, 2);
          push_idle(1'b1);
        end else begin
          io_start = 1'b0;
        end
        @(negedge io_clk);
      end
      io_start = 1'b0;
    end

    // Reset mid-ACTIVE aborts immediately, with no done afterwards.
    set_cfg(1'b1, 100, 5, 1);
    io_start = 1'b1;
    @(negedge io_clk);
    io_start = 1'b0;
    repeat (10) @(negedge io_clk);
    check("mid_active", 1'b0, 1'b1, 1'b0);
    io_rst = 1'b1;
    #1;
    check("async_reset", 1'b0, 1'b0, 1'b0);
    @(negedge io_clk);
    io_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge io_clk);
      check("post_reset", 1'b1, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
